// File: rtl/rcv_bit_decoder.sv
// rcv_bit_decoder: USB receive bit recovery.
// Re-aligns its sampling phase on every line edge and samples once per bit period.
// It NRZI-decodes each sampled level and drops stuffed bits.
// Each recovered data bit is presented as a one-cycle bit_valid strobe.
// A missing stuff bit is reported as a one-cycle stuff_err strobe.
module rcv_bit_decoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3,
  parameter int STUFF_LEN    = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic d_plus,
  input  logic d_edge,
  output logic bit_out,
  output logic bit_valid,
  output logic stuff_err
);

  localparam int PHASE_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W   = $clog2(STUFF_LEN + 1);

  localparam logic [PHASE_W-1:0] PHASE_LAST   = PHASE_W'(CLKS_PER_BIT - 1);
  localparam logic [PHASE_W-1:0] PHASE_SAMPLE = PHASE_W'(SAMPLE_POINT);
  localparam logic [CNT_W-1:0]   CNT_LIMIT    = CNT_W'(STUFF_LEN);

  // Registered state
  logic [PHASE_W-1:0] r_phase;
  logic               r_prev_level;
  logic [CNT_W-1:0]   r_ones_cnt;
  logic               r_bit_out;
  logic               r_bit_valid;
  logic               r_stuff_err;

  // Next-state values
  logic [PHASE_W-1:0] w_phase_next;
  logic               w_prev_level_next;
  logic [CNT_W-1:0]   w_ones_cnt_next;
  logic               w_bit_out_next;
  logic               w_bit_valid_next;
  logic               w_stuff_err_next;

  // Decode helpers
  logic w_sample;
  logic w_decoded;
  logic w_stuff_due;

  // A sample happens only on the sample phase, and only if no edge arrives in the same cycle.
  // An edge in that cycle means the bit boundary moved, so the old phase is not trusted.
  assign w_sample    = enable && (r_phase == PHASE_SAMPLE) && !d_edge;
  // In NRZI, an unchanged level means 1 and a level transition means 0.
  assign w_decoded   = (d_plus == r_prev_level);
  // After STUFF_LEN consecutive 1s, the next sampled bit must be a stuff bit.
  assign w_stuff_due = (r_ones_cnt >= CNT_LIMIT);

  // Next-state logic: phase tracking, NRZI decode and bit unstuffing
  always_comb begin
    w_phase_next      = r_phase;
    w_prev_level_next = r_prev_level;
    w_ones_cnt_next   = r_ones_cnt;
    w_bit_out_next    = r_bit_out;
    w_bit_valid_next  = 1'b0;
    w_stuff_err_next  = 1'b0;

    if (!enable) begin
      // Outside the receive window, everything returns to idle except the last data bit.
      w_phase_next      = '0;
      w_prev_level_next = 1'b1;
      w_ones_cnt_next   = '0;
    end else begin
      if (d_edge) begin
        w_phase_next = '0;
      end else if (r_phase == PHASE_LAST) begin
        w_phase_next = '0;
      end else begin
        w_phase_next = r_phase + 1'b1;
      end

      if (w_sample) begin
        w_prev_level_next = d_plus;
        if (!w_stuff_due) begin
          w_bit_valid_next = 1'b1;
          w_bit_out_next   = w_decoded;
          w_ones_cnt_next  = w_decoded ? (r_ones_cnt + 1'b1) : '0;
        end else begin
          // The expected stuff bit is consumed here.
          // A 1 in its place means the transmitter broke the stuffing rule.
          w_stuff_err_next = w_decoded;
          w_ones_cnt_next  = '0;
        end
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase      <= '0;
      r_prev_level <= 1'b1;
      r_ones_cnt   <= '0;
      r_bit_out    <= 1'b0;
      r_bit_valid  <= 1'b0;
      r_stuff_err  <= 1'b0;
    end else begin
      r_phase      <= w_phase_next;
      r_prev_level <= w_prev_level_next;
      r_ones_cnt   <= w_ones_cnt_next;
      r_bit_out    <= w_bit_out_next;
      r_bit_valid  <= w_bit_valid_next;
      r_stuff_err  <= w_stuff_err_next;
    end
  end

  assign bit_out   = r_bit_out;
  assign bit_valid = r_bit_valid;
  assign stuff_err = r_stuff_err;

endmodule
